// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - serial frame receiver with start/stop framing and a one-word output buffer
module sipo_frame_rx #(
    parameter int N         = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_en,
    input  logic         sin,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         frm_err,
    output logic         ovr_err,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   sh;

    logic cnt_clr;
    logic shift;
    logic good_stop;
    logic bad_stop;
    logic load;
    logic overrun;
    logic drain;

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift      = 1'b0;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            IDLE: begin
                if (bit_en && !sin) begin
                    state_next = DATA;
                    cnt_clr    = 1'b1;
                end
            end
            DATA: begin
                if (bit_en) begin
                    shift = 1'b1;
                    if (cnt == LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_en) begin
                    state_next = IDLE;
                    good_stop  = sin;
                    bad_stop   = !sin;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A good frame may load on the very edge the consumer drains the old word.
    assign drain   = dout_valid && dout_ready;
    assign load    = good_stop && (!dout_valid || dout_ready);
    assign overrun = good_stop && dout_valid && !dout_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frm_err    <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            state   <= state_next;
            frm_err <= bad_stop;
            ovr_err <= overrun;

            if (cnt_clr) begin
                cnt <= '0;
            end else if (shift && cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end

            if (shift) begin
                if (MSB_FIRST != 0) begin
                    sh <= {sh[N-2:0], sin};
                end else begin
                    sh <= {sin, sh[N-1:1]};
                end
            end

            if (load) begin
                dout       <= sh;
                dout_valid <= 1'b1;
            end else if (drain) begin
                dout_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb/tb_sipo_frame_rx.sv - directed self-checking bench for sipo_frame_rx
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       sin = 1'b1;
    logic       dout_ready = 1'b1;

    logic [7:0] dout;
    logic       dout_valid;
    logic       frm_err;
    logic       ovr_err;
    logic       busy;

    logic [7:0] dout_m;
    logic       dout_valid_m;
    logic       frm_err_m;
    logic       ovr_err_m;
    logic       busy_m;

    int total = 0;
    int bad = 0;
    logic in_frame = 1'b0;
    logic busy_gap = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_rx #(.N(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .frm_err(frm_err), .ovr_err(ovr_err), .busy(busy)
    );

    sipo_frame_rx #(.N(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
        .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
        .frm_err(frm_err_m), .ovr_err(ovr_err_m), .busy(busy_m)
    );

    always @(negedge clk) begin
        if (in_frame && busy !== 1'b1) busy_gap = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic b);
        sin = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        sin = 1'b1;
    endtask

    // seq[i] is the i-th data bit on the line; returns just after the stop-bit edge
    task automatic send_frame(input logic [7:0] seq, input logic stop, input int gap,
                              input logic ready_on_stop);
        busy_gap = 1'b0;
        strobe(1'b0);
        in_frame = 1'b1;
        idle(gap - 1);
        for (int i = 0; i < 8; i++) begin
            strobe(seq[i]);
            idle(gap - 1);
        end
        in_frame = 1'b0;
        if (ready_on_stop) dout_ready = 1'b1;
        strobe(stop);
        if (ready_on_stop) dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got %h want 00", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        total++; if ({frm_err, ovr_err} !== 2'b00) begin bad++; $display("FAIL reset_err got %b want 00", {frm_err, ovr_err}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        idle(2);
    endtask

    task automatic test_lsb_msb();
        dout_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 4, 1'b0);
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL a5_valid got %b want 1", dout_valid); end
        total++; if (dout !== 8'hA5) begin bad++; $display("FAIL a5_dout got %h want a5", dout); end
        total++; if (dout_m !== 8'hA5 || dout_valid_m !== 1'b1) begin bad++; $display("FAIL a5_msb got %h/%b want a5/1", dout_m, dout_valid_m); end
        total++; if (busy_gap !== 1'b0) begin bad++; $display("FAIL a5_busy_during got gap=%b want 0", busy_gap); end
        total++; if (busy !== 1'b0 || busy_m !== 1'b0) begin bad++; $display("FAIL a5_busy_after got %b%b want 00", busy, busy_m); end
        total++; if (frm_err !== 1'b0 || ovr_err !== 1'b0) begin bad++; $display("FAIL a5_err got %b%b want 00", frm_err, ovr_err); end
        tick();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL a5_drain got %b want 0", dout_valid); end
        idle(3);
        send_frame(8'h03, 1'b1, 4, 1'b0);
        total++; if (dout !== 8'h03) begin bad++; $display("FAIL x03_lsb got %h want 03", dout); end
        total++; if (dout_m !== 8'hC0) begin bad++; $display("FAIL x03_msb got %h want c0", dout_m); end
        idle(4);
    endtask

    task automatic test_framing();
        dout_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 4, 1'b0);
        total++; if (frm_err !== 1'b1 || frm_err_m !== 1'b1) begin bad++; $display("FAIL frm_pulse got %b%b want 11", frm_err, frm_err_m); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL frm_valid got %b want 0", dout_valid); end
        total++; if (busy !== 1'b0 || ovr_err !== 1'b0) begin bad++; $display("FAIL frm_state got busy=%b ovr=%b want 0 0", busy, ovr_err); end
        tick();
        total++; if (frm_err !== 1'b0) begin bad++; $display("FAIL frm_width got %b want 0", frm_err); end
        idle(3);
        send_frame(8'h81, 1'b1, 4, 1'b0);
        total++; if (dout !== 8'h81 || dout_valid !== 1'b1) begin bad++; $display("FAIL frm_next got %h/%b want 81/1", dout, dout_valid); end
        total++; if (frm_err !== 1'b0) begin bad++; $display("FAIL frm_next_err got %b want 0", frm_err); end
        idle(4);
    endtask

    task automatic test_overrun();
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b1, 4, 1'b0);
        idle(3);
        send_frame(8'h22, 1'b1, 4, 1'b0);
        total++; if (ovr_err !== 1'b1) begin bad++; $display("FAIL ovr_pulse got %b want 1", ovr_err); end
        total++; if (frm_err !== 1'b0) begin bad++; $display("FAIL ovr_frm got %b want 0", frm_err); end
        total++; if (dout !== 8'h11 || dout_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold got %h/%b want 11/1", dout, dout_valid); end
        tick();
        total++; if (ovr_err !== 1'b0) begin bad++; $display("FAIL ovr_width got %b want 0", ovr_err); end
        dout_ready = 1'b1;
        tick();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got %b want 0", dout_valid); end
        idle(3);
    endtask

    task automatic test_simul_drain_load();
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b1, 4, 1'b0);
        idle(3);
        send_frame(8'h22, 1'b1, 4, 1'b1);
        total++; if (ovr_err !== 1'b0) begin bad++; $display("FAIL sim_ovr got %b want 0", ovr_err); end
        total++; if (dout_valid !== 1'b1 || dout !== 8'h22) begin bad++; $display("FAIL sim_load got %h/%b want 22/1", dout, dout_valid); end
        idle(2);
        total++; if (dout !== 8'h22 || dout_valid !== 1'b1) begin bad++; $display("FAIL sim_stable got %h/%b want 22/1", dout, dout_valid); end
        dout_ready = 1'b1;
        tick();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL sim_drain got %b want 0", dout_valid); end
        idle(3);
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b0;
        send_frame(8'h77, 1'b1, 4, 1'b0);
        idle(3);
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin bad++; $display("FAIL rmid_buf got %h/%b want 00/0", dout, dout_valid); end
        total++; if ({busy, frm_err, ovr_err} !== 3'b000) begin bad++; $display("FAIL rmid_ctl got %b want 000", {busy, frm_err, ovr_err}); end
        dout_ready = 1'b1;
        idle(3);
        send_frame(8'h5A, 1'b1, 4, 1'b0);
        total++; if (dout !== 8'h5A || dout_valid !== 1'b1) begin bad++; $display("FAIL rmid_next got %h/%b want 5a/1", dout, dout_valid); end
        total++; if (frm_err !== 1'b0 || ovr_err !== 1'b0) begin bad++; $display("FAIL rmid_err got %b%b want 00", frm_err, ovr_err); end
        idle(4);
    endtask

    task automatic test_back_to_back();
        dout_ready = 1'b1;
        send_frame(8'h12, 1'b1, 1, 1'b0);
        total++; if (dout !== 8'h12 || dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got %h/%b want 12/1", dout, dout_valid); end
        send_frame(8'h34, 1'b1, 1, 1'b0);
        total++; if (dout !== 8'h34 || dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got %h/%b want 34/1", dout, dout_valid); end
        total++; if (busy_gap !== 1'b0) begin bad++; $display("FAIL b2b_busy got gap=%b want 0", busy_gap); end
        total++; if (ovr_err !== 1'b0 || frm_err !== 1'b0) begin bad++; $display("FAIL b2b_err got %b%b want 00", ovr_err, frm_err); end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_lsb_msb();
        test_framing();
        test_overrun();
        test_simul_drain_load();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-in/parallel-out frame receiver: the receiving end of the team's shift-register serial link. It detects a start bit, shifts in N data bits (LSB- or MSB-first) on an external bit-rate strobe, checks the stop bit, and presents each good word on a one-entry valid/ready output buffer. It sits between the line-side bit strobe generator and the word-level consumer logic, flagging framing and overrun errors.

## Interface
- N, default 8: data bits per frame (N >= 2).
- MSB_FIRST, default 0: 0 means the first data bit received is dout[0]; 1 means the first data bit received is dout[N-1].

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- bit_en  input  1  one-cycle strobe per bit period; sin is sampled only on cycles where bit_en=1.
- sin  input  1  serial line; idle high, start bit 0, N data bits, stop bit 1.
- dout  output  N  received word; valid while dout_valid=1.
- dout_valid  output  1  output buffer holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
- frm_err  output  1  one-cycle pulse: stop bit sampled as 0.
- ovr_err  output  1  one-cycle pulse: good frame completed while buffer full and not draining.
- busy  output  1  1 whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, DATA, STOP. busy is decoded from the state register.
- When bit_en=0, state, counter and shift register hold; no sampling takes place.
- IDLE: on bit_en with sin=0, go to DATA and clear bit counter cnt (width $clog2(N)). On bit_en with sin=1, stay in IDLE.
- DATA: each bit_en shifts sin into the shift register.
  - MSB_FIRST=0: sh <= {sin, sh[N-1:1]} (right shift, sin enters at MSB).
  - MSB_FIRST=1: sh <= {sh[N-2:0], sin} (left shift, sin enters at LSB).
  - cnt increments per bit. On the bit_en where cnt==N-1, go to STOP. cnt never wraps past N-1.
- STOP, on bit_en:
  - sin=1 (good frame), and buffer free or draining this edge (dout_valid=0, or dout_ready=1): dout <= sh, dout_valid <= 1.
  - sin=1, and buffer full and not draining: ovr_err pulses. The new word is dropped; dout and dout_valid are unchanged.
  - sin=0: frm_err pulses and the word is discarded. The buffer is untouched.
  - In all three cases, return to IDLE. Start detection resumes on the next bit_en, so a held-low line re-triggers a frame.
- Output buffer:
  - dout_valid clears on an edge with dout_valid && dout_ready, unless a good frame loads on the same edge; then it stays 1 and dout takes the new word.
  - dout is stable while dout_valid && !dout_ready.
- Receive continues independently of buffer state; the FSM never stalls.

## Timing
- Reset (rst_n=0 at an edge) forces state=IDLE, cnt=0, sh=0, dout=0, dout_valid=0, frm_err=0, ovr_err=0, busy=0. This applies mid-frame and mid-handshake: the partial frame and any buffered word are lost.
- dout_valid, frm_err and ovr_err are registered. They change on the edge that samples the stop bit and are visible in the following cycle.
- A frame takes N+2 bit_en strobes (start, N data, stop). End-to-end latency from the stop-bit strobe edge to dout_valid is 1 clock.
- frm_err and ovr_err are high for exactly one clock per event; never both in the same cycle.
- Back-to-back frames are supported: the start bit may arrive on the bit_en immediately following the stop bit.
- A bit_en on consecutive clocks is legal. Behaviour is identical to spaced strobes.

## Test plan
- N=8, MSB_FIRST=0, dout_ready=1. Strobe sin = 0, 1,0,1,0,0,1,0,1, 1 with bit_en every 4th cycle -> dout=8'hA5, dout_valid high 1 cycle after the stop edge, then low 1 cycle later. busy high from start-bit edge to stop-bit edge.
- N=8, MSB_FIRST=1, same bit sequence -> dout=8'hA5 (bits 1,0,1,0,0,1,0,1 MSB-first). With MSB_FIRST=0, the sequence 1,1,0,0,0,0,0,0 -> dout=8'h03.
- Framing: send 8'h3C with stop bit 0 -> frm_err pulses once, dout_valid stays 0, FSM in IDLE. The next good frame 8'h81 is received correctly.
- Overrun: dout_ready=0, send 8'h11 then 8'h22 -> dout=8'h11 held, ovr_err pulses once at the second stop. Raising dout_ready then drains 8'h11, and dout_valid falls.
- Simultaneous drain/load: hold 8'h11 with dout_ready=0, send 8'h22, and assert dout_ready only on the stop-bit edge -> no ovr_err, dout_valid stays 1, dout=8'h22.
- Reset mid-frame: pull rst_n low after 4 data bits -> all outputs 0 next cycle. A fresh full frame 8'h5A afterwards -> dout=8'h5A, no errors.
